// File: rtl/ring_shift_reg.sv
// Multi-mode shift register: rotate, shift, Johnson and LFSR sequencing with parallel load.
// A step counter pulses wrap once per period of the active mode.
module ring_shift_reg #(
    parameter int                WIDTH = 4,
    parameter logic [WIDTH-1:0]  INIT  = WIDTH'(1),
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(4'b1100)
) (
    input  logic                          ck,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic                          si,
    input  logic [WIDTH-1:0]              load_d,
    output logic [WIDTH-1:0]              d,
    output logic                          so,
    output logic [$clog2(2*WIDTH)-1:0]    step,
    output logic                          wrap
);

    localparam int SW = $clog2(2*WIDTH);

    localparam logic [2:0] M_HOLD    = 3'd0;
    localparam logic [2:0] M_ROTL    = 3'd1;
    localparam logic [2:0] M_ROTR    = 3'd2;
    localparam logic [2:0] M_SHL     = 3'd3;
    localparam logic [2:0] M_SHR     = 3'd4;
    localparam logic [2:0] M_JOHNSON = 3'd5;
    localparam logic [2:0] M_LFSR    = 3'd6;
    localparam logic [2:0] M_LOAD    = 3'd7;

    logic [WIDTH-1:0] r_q;
    logic [SW-1:0]    r_step;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q_nxt;
    logic [SW-1:0]    w_step_nxt;
    logic [SW-1:0]    w_last;
    logic             w_active;
    logic             w_wrap;
    logic             w_fb;

    assign w_active = (mode != M_HOLD) && (mode != M_LOAD);
    assign w_last   = (mode == M_JOHNSON) ? SW'(2*WIDTH - 1) : SW'(WIDTH - 1);
    // ">=" rather than "==" so a step count left over from a longer period still wraps.
    assign w_wrap   = en && w_active && (r_step >= w_last);
    // An all-zero LFSR would lock up; inject a 1 to escape.
    assign w_fb     = (r_q == '0) ? 1'b1 : ^(r_q & TAPS);

    always_comb begin
        w_q_nxt = r_q;
        if (en) begin
            case (mode)
                M_ROTL:    w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                M_ROTR:    w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                M_SHL:     w_q_nxt = {r_q[WIDTH-2:0], si};
                M_SHR:     w_q_nxt = {si, r_q[WIDTH-1:1]};
                M_JOHNSON: w_q_nxt = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
                M_LFSR:    w_q_nxt = {r_q[WIDTH-2:0], w_fb};
                M_LOAD:    w_q_nxt = load_d;
                default:   w_q_nxt = r_q;
            endcase
        end
    end

    always_comb begin
        w_step_nxt = r_step;
        if (en) begin
            if (mode == M_LOAD) begin
                w_step_nxt = '0;
            end else if (w_active) begin
                w_step_nxt = w_wrap ? '0 : r_step + SW'(1);
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= INIT;
            r_step <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_step <= w_step_nxt;
            r_wrap <= w_wrap;
        end
    end

    assign d    = r_q;
    assign step = r_step;
    assign wrap = r_wrap;
    assign so   = ((mode == M_ROTR) || (mode == M_SHR)) ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: tb/tb_ring_shift_reg.sv
// Directed bench for ring_shift_reg: a WIDTH=4 default instance and a WIDTH=8, INIT=8'h81 instance.
module tb_ring_shift_reg;

    logic       ck = 1'b0;
    always #5 ck = ~ck;

    logic       rst_n4, en4, si4;
    logic [2:0] mode4;
    logic [3:0] load4, d4;
    logic       so4, wrap4;
    logic [2:0] step4;

    logic       rst_n8, en8, si8;
    logic [2:0] mode8;
    logic [7:0] load8, d8;
    logic       so8, wrap8;
    logic [3:0] step8;

    ring_shift_reg dut4 (
        .ck(ck), .rst_n(rst_n4), .en(en4), .mode(mode4), .si(si4), .load_d(load4),
        .d(d4), .so(so4), .step(step4), .wrap(wrap4)
    );

    ring_shift_reg #(.WIDTH(8), .INIT(8'h81), .TAPS(8'hB8)) dut8 (
        .ck(ck), .rst_n(rst_n8), .en(en8), .mode(mode8), .si(si8), .load_d(load8),
        .d(d8), .so(so8), .step(step8), .wrap(wrap8)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic si, input logic [3:0] ld);
        en4 = en; mode4 = mode; si4 = si; load4 = ld;
    endtask

    task automatic reset4();
        @(negedge ck);
        rst_n4 = 1'b0;
        #2;
        rst_n4 = 1'b1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] ed, input logic [2:0] es, input logic ew);
        check({tag, "_d"},    32'(d4),    32'(ed));
        check({tag, "_step"}, 32'(step4), 32'(es));
        check({tag, "_wrap"}, 32'(wrap4), 32'(ew));
    endtask

    logic [3:0] rotl_exp [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] shr_exp  [3] = '{4'hD, 4'hE, 4'hF};
    logic       shr_so   [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] john_exp [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] lfsr_exp [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [7:0] rot8_exp [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    initial begin
        rst_n4 = 1'b0; drive(1'b0, 3'd0, 1'b0, 4'h0);
        rst_n8 = 1'b0; en8 = 1'b0; mode8 = 3'd0; si8 = 1'b0; load8 = 8'h00;
        #12;
        chk4("reset", 4'h1, 3'd0, 1'b0);
        check("reset_so", 32'(so4), 32'd0);
        @(negedge ck);
        rst_n4 = 1'b1;
        rst_n8 = 1'b1;

        // ROTL from reset
        drive(1'b1, 3'd1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4($sformatf("rotl%0d", i), rotl_exp[i], 3'((i + 1) % 4), (i == 3));
        end

        // HOLD keeps d and step, clears wrap
        drive(1'b1, 3'd0, 1'b0, 4'h0);
        tick();
        chk4("hold", 4'h1, 3'd0, 1'b0);

        // ROTR with an en=0 gap after the second edge
        reset4();
        drive(1'b1, 3'd2, 1'b0, 4'h0);
        tick(); chk4("rotr0", 4'h8, 3'd1, 1'b0);
        check("rotr_so", 32'(so4), 32'd0);
        tick(); chk4("rotr1", 4'h4, 3'd2, 1'b0);
        drive(1'b0, 3'd2, 1'b0, 4'h0);
        tick(); chk4("rotr_gap0", 4'h4, 3'd2, 1'b0);
        tick(); chk4("rotr_gap1", 4'h4, 3'd2, 1'b0);
        drive(1'b1, 3'd2, 1'b0, 4'h0);
        tick(); chk4("rotr2", 4'h2, 3'd3, 1'b0);
        tick(); chk4("rotr3", 4'h1, 3'd0, 1'b1);

        // LOAD then SHR with si=1
        drive(1'b1, 3'd7, 1'b0, 4'hA);
        tick(); chk4("load_a", 4'hA, 3'd0, 1'b0);
        drive(1'b1, 3'd4, 1'b1, 4'h0);
        #1 check("shr_so_init", 32'(so4), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4($sformatf("shr%0d", i), shr_exp[i], 3'(i + 1), 1'b0);
            check($sformatf("shr_so%0d", i), 32'(so4), 32'(shr_so[i]));
        end

        // SHL
        drive(1'b1, 3'd7, 1'b0, 4'h0);
        tick();
        drive(1'b1, 3'd3, 1'b1, 4'h0);
        tick(); chk4("shl0", 4'h1, 3'd1, 1'b0);
        tick(); chk4("shl1", 4'h3, 3'd2, 1'b0);
        drive(1'b1, 3'd3, 1'b0, 4'h0);
        tick(); chk4("shl2", 4'h6, 3'd3, 1'b0);
        check("shl_so", 32'(so4), 32'd0);

        // JOHNSON from 0000: 8-step period
        drive(1'b1, 3'd7, 1'b0, 4'h0);
        tick(); chk4("load_0", 4'h0, 3'd0, 1'b0);
        drive(1'b1, 3'd5, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk4($sformatf("john%0d", i), john_exp[i], 3'((i + 1) % 8), (i == 7));
        end

        // Mode change JOHNSON(step 6) -> ROTL wraps at once
        drive(1'b1, 3'd7, 1'b0, 4'h0);
        tick();
        drive(1'b1, 3'd5, 1'b0, 4'h0);
        repeat (6) tick();
        chk4("john6", 4'hC, 3'd6, 1'b0);
        drive(1'b1, 3'd1, 1'b0, 4'h0);
        tick(); chk4("modechg", 4'h9, 3'd0, 1'b1);

        // LFSR full sequence from 0001
        drive(1'b1, 3'd7, 1'b0, 4'h1);
        tick();
        drive(1'b1, 3'd6, 1'b0, 4'h0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk4($sformatf("lfsr%0d", i), lfsr_exp[i], 3'((i + 1) % 4), ((i + 1) % 4 == 0));
        end

        // LFSR lock-up escape
        drive(1'b1, 3'd7, 1'b0, 4'h0);
        tick();
        drive(1'b1, 3'd6, 1'b0, 4'h0);
        tick(); chk4("lfsr_escape", 4'h1, 3'd1, 1'b0);

        // Async reset mid-ROTL with ck stable
        reset4();
        drive(1'b1, 3'd1, 1'b0, 4'h0);
        tick(); tick();
        chk4("pre_areset", 4'h4, 3'd2, 1'b0);
        #2 rst_n4 = 1'b0;
        #1 chk4("areset", 4'h1, 3'd0, 1'b0);
        check("areset_so", 32'(so4), 32'd0);
        @(negedge ck);
        rst_n4 = 1'b1;

        // WIDTH=8 instance: ROTL returns to 81 after 8 edges
        check("w8_reset", 32'(d8), 32'h81);
        check("w8_so", 32'(so8), 32'd1);
        en8 = 1'b1; mode8 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("w8_rotl%0d_d", i), 32'(d8), 32'(rot8_exp[i]));
            check($sformatf("w8_rotl%0d_wrap", i), 32'(wrap8), 32'(i == 7));
            check($sformatf("w8_rotl%0d_step", i), 32'(step8), 32'((i + 1) % 8));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        n_bad++;
        $display("FAIL timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
